// File: rtl/fp16_to_fixed_8_pkg.sv
// Shared constants, class encoding and stage-1 payload for the FP16 -> Q8.8 converter.
package fp16_to_fixed_8_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned FP16_EXP_W    = 5;
    localparam int unsigned FP16_MANT_W   = 10;
    localparam int unsigned FP16_EXP_BIAS = 15;
    localparam int unsigned Q_FRAC_BITS   = 8;
    localparam int unsigned Q88_W         = 16;

    // Significand width including the hidden one
    localparam int unsigned SIG_W  = FP16_MANT_W + 1;
    // Unsigned magnitude width carried between stages
    localparam int unsigned MAG_W  = 17;
    // Magnitude width after the rounding increment
    localparam int unsigned MAGR_W = MAG_W + 1;
    // Right-shift working width: significand plus room for every shifted-out bit
    localparam int unsigned EXT_W  = SIG_W + MAG_W;

    // Exponent at which the significand LSB lands exactly on the Q8.8 LSB
    localparam int unsigned Q_ALIGN_EXP = FP16_EXP_BIAS + FP16_MANT_W - Q_FRAC_BITS;
    // From this exponent up every value exceeds the Q8.8 range
    localparam int unsigned EXP_SAT_MIN = Q_ALIGN_EXP + MAG_W - SIG_W;

    localparam logic [Q88_W-1:0] Q88_SAT_POS = 16'h7FFF;
    localparam logic [Q88_W-1:0] Q88_SAT_NEG = 16'h8000;
    localparam logic [Q88_W-1:0] Q88_NAN_VAL = 16'h0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Decoded operand held between stage 1 and stage 2
    typedef struct packed {
        logic             sign;
        fp_class_t        cls;
        logic [MAG_W-1:0] mag;
        logic             guard;
        logic             sticky;
    } s1_payload_t;

endpackage

// File: rtl/fp16_q88_round.sv
// Stage-2 combinational logic: round the magnitude, apply the sign, saturate, set flags.
// Rounding mode: FP16_TO_FIXED8_RNE_EN defined -> nearest-even, undefined -> truncate.
module fp16_q88_round
    import fp16_to_fixed_8_pkg::*;
(
    input  s1_payload_t      s1,
    output logic [Q88_W-1:0] fixed_c,
    output logic             sat_c,
    output logic             nan_c
);

    logic              round_up_c;
    logic [MAGR_W-1:0] mag_r_c;
    logic              unused_rnd_c;

`ifdef FP16_TO_FIXED8_RNE_EN
    assign round_up_c   = s1.guard & (s1.sticky | s1.mag[0]);
    assign unused_rnd_c = 1'b0;
`else
    assign round_up_c   = 1'b0;
    assign unused_rnd_c = s1.guard ^ s1.sticky;
`endif

    // Rounding carry is kept in the extra bit so it can push the value into saturation
    assign mag_r_c = {1'b0, s1.mag} + MAGR_W'(round_up_c);

    // Class-driven result selection with signed saturation
    always_comb begin
        fixed_c = Q88_NAN_VAL;
        sat_c   = 1'b0;
        nan_c   = 1'b0;
        case (s1.cls)
            FP_NAN: begin
                nan_c = 1'b1;
            end
            FP_INF: begin
                fixed_c = s1.sign ? Q88_SAT_NEG : Q88_SAT_POS;
                sat_c   = 1'b1;
            end
            FP_NORMAL: begin
                if (!s1.sign) begin
                    if (mag_r_c > MAGR_W'(Q88_SAT_POS)) begin
                        fixed_c = Q88_SAT_POS;
                        sat_c   = 1'b1;
                    end else begin
                        fixed_c = mag_r_c[Q88_W-1:0];
                    end
                end else begin
                    if (mag_r_c > MAGR_W'(Q88_SAT_NEG)) begin
                        fixed_c = Q88_SAT_NEG;
                        sat_c   = 1'b1;
                    end else begin
                        fixed_c = ~mag_r_c[Q88_W-1:0] + 16'd1;
                    end
                end
            end
            default: begin
                fixed_c = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/fp16_to_fixed_8.sv
// Two-stage FP16 -> signed Q8.8 converter, latency 2, one operand per cycle.
// Optional round-to-nearest-even build: define FP16_TO_FIXED8_RNE_EN.
module fp16_to_fixed_8
    import fp16_to_fixed_8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FP16_W-1:0] fp16,
    output logic              out_valid,
    output logic [Q88_W-1:0]  fixed8,
    output logic              sat,
    output logic              nan
);

    logic [FP16_EXP_W-1:0]  exp_c;
    logic [FP16_MANT_W-1:0] mant_c;
    logic [SIG_W-1:0]       sig_c;
    logic [FP16_EXP_W-1:0]  rsh_c;
    logic [FP16_EXP_W-1:0]  lsh_c;
    logic [EXT_W-1:0]       ext_c;
    s1_payload_t            dec_c;

    logic                   v1_d, v1_q;
    s1_payload_t            s1_d, s1_q;

    logic [Q88_W-1:0]       rnd_fixed_c;
    logic                   rnd_sat_c, rnd_nan_c;

    logic                   v2_d, v2_q;
    logic [Q88_W-1:0]       fixed_d, fixed_q;
    logic                   sat_d, sat_q;
    logic                   nan_d, nan_q;

    // Field split and alignment shifts
    always_comb begin
        exp_c  = fp16[FP16_W-2 -: FP16_EXP_W];
        mant_c = fp16[FP16_MANT_W-1:0];
        sig_c  = {1'b1, mant_c};
        rsh_c  = FP16_EXP_W'(Q_ALIGN_EXP) - exp_c;
        lsh_c  = exp_c - FP16_EXP_W'(Q_ALIGN_EXP);
        ext_c  = {sig_c, MAG_W'(0)} >> rsh_c;
    end

    // Classify operand and form magnitude with guard/sticky
    always_comb begin
        dec_c      = '0;
        dec_c.sign = fp16[FP16_W-1];
        dec_c.cls  = FP_ZERO;
        if (exp_c == '1) begin
            dec_c.cls = (mant_c != '0) ? FP_NAN : FP_INF;
        end else if (exp_c != '0) begin
            dec_c.cls = FP_NORMAL;
            if (exp_c >= FP16_EXP_W'(EXP_SAT_MIN)) begin
                // Far beyond range; an all-ones magnitude forces saturation
                dec_c.mag = '1;
            end else if (exp_c >= FP16_EXP_W'(Q_ALIGN_EXP)) begin
                dec_c.mag = MAG_W'(sig_c) << lsh_c;
            end else begin
                dec_c.mag    = MAG_W'(ext_c[EXT_W-1:MAG_W]);
                dec_c.guard  = ext_c[MAG_W-1];
                dec_c.sticky = |ext_c[MAG_W-2:0];
            end
        end
    end

    // Stage-1 next state: load on valid input, hold otherwise
    always_comb begin
        v1_d = in_valid;
        s1_d = s1_q;
        if (in_valid) begin
            s1_d = dec_c;
        end
    end

    fp16_q88_round u_round (
        .s1      (s1_q),
        .fixed_c (rnd_fixed_c),
        .sat_c   (rnd_sat_c),
        .nan_c   (rnd_nan_c)
    );

    // Stage-2 next state: load on stage-1 valid, hold otherwise
    always_comb begin
        v2_d    = v1_q;
        fixed_d = fixed_q;
        sat_d   = sat_q;
        nan_d   = nan_q;
        if (v1_q) begin
            fixed_d = rnd_fixed_c;
            sat_d   = rnd_sat_c;
            nan_d   = rnd_nan_c;
        end
    end

    // Pipeline registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            v2_q    <= 1'b0;
            fixed_q <= '0;
            sat_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            v2_q    <= v2_d;
            fixed_q <= fixed_d;
            sat_q   <= sat_d;
            nan_q   <= nan_d;
        end
    end

    assign out_valid = v2_q;
    assign fixed8    = fixed_q;
    assign sat       = sat_q;
    assign nan       = nan_q;

endmodule

// File: tb/tb_fp16_to_fixed_8.sv
// Self-checking bench for fp16_to_fixed_8: directed values, specials, range edges,
// rounding cases, streaming with gaps, mid-stream reset and randomized operands.
module tb_fp16_to_fixed_8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] fp16;
    logic        out_valid;
    logic [15:0] fixed8;
    logic        sat;
    logic        nan;

    int n_cmp;
    int n_err;

`ifdef FP16_TO_FIXED8_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Expected {nan, sat, fixed} for 0x1E00 (exactly 1.5 LSB)
    localparam logic [17:0] E_1E00 = RNE ? 18'h00002 : 18'h00001;

    typedef struct {
        logic        v;
        logic [15:0] x;
        logic [17:0] e;
    } exp_t;

    exp_t last;

    fp16_to_fixed_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .fp16      (fp16),
        .out_valid (out_valid),
        .fixed8    (fixed8),
        .sat       (sat),
        .nan       (nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact real value scaled by 256, rounded per build, then clamped
    function automatic logic [17:0] model(input logic [15:0] x);
        int     e;
        int     m;
        logic   sgn;
        real    mag;
        real    frac;
        longint fl;
        logic   up;
        e   = int'(x[14:10]);
        m   = int'(x[9:0]);
        sgn = x[15];
        if (e == 31) begin
            if (m != 0) return {1'b1, 1'b0, 16'h0000};
            return {1'b0, 1'b1, sgn ? 16'h8000 : 16'h7FFF};
        end
        if (e == 0) return 18'h0;
        mag = (1.0 + real'(m) / 1024.0) * 256.0;
        for (int k = 15; k < e; k++) mag = mag * 2.0;
        for (int k = e; k < 15; k++) mag = mag / 2.0;
        fl   = longint'($floor(mag));
        frac = mag - real'(fl);
        up   = (frac > 0.5) || (frac == 0.5 && (fl % 2) == 1);
        if (RNE && up) fl = fl + 1;
        if (!sgn) begin
            if (fl > 32767) return {1'b0, 1'b1, 16'h7FFF};
            return {1'b0, 1'b0, 16'(fl)};
        end
        if (fl > 32768) return {1'b0, 1'b1, 16'h8000};
        return {1'b0, 1'b0, 16'(-fl)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Check the output stage against the operand issued one step earlier
    task automatic check_out();
        chk($sformatf("out_valid[x=%h]", last.x), 32'(out_valid), 32'(last.v));
        if (last.v) begin
            chk($sformatf("result[x=%h] {nan,sat,fixed}", last.x),
                32'({nan, sat, fixed8}), 32'(last.e));
        end
    endtask

    // One clock of stimulus; use_const selects a hard-coded expectation over the model
    task automatic step(input logic v, input logic [15:0] x,
                        input logic use_const, input logic [17:0] cexp);
        exp_t cur;
        @(negedge clk);
        in_valid = v;
        fp16     = x;
        cur.v    = v;
        cur.x    = x;
        cur.e    = use_const ? cexp : model(x);
        @(posedge clk);
        #1;
        check_out();
        last = cur;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        fp16     = 16'h0000;
        last.v   = 1'b0;
        last.x   = 16'h0000;
        last.e   = 18'h0;

        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset outputs", 32'({nan, sat, fixed8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reference, specials and range edges streamed back to back
        step(1'b1, 16'h0000, 1'b1, 18'h00000);
        step(1'b1, 16'h3C00, 1'b1, 18'h00100);
        step(1'b1, 16'hBC00, 1'b1, 18'h0FF00);
        step(1'b1, 16'h4000, 1'b1, 18'h00200);
        step(1'b1, 16'h3400, 1'b1, 18'h00040);
        step(1'b1, 16'h03FF, 1'b1, 18'h00000);
        step(1'b1, 16'h8000, 1'b1, 18'h00000);
        step(1'b1, 16'h7C00, 1'b1, 18'h17FFF);
        step(1'b1, 16'hFC00, 1'b1, 18'h18000);
        step(1'b1, 16'h7E00, 1'b1, 18'h20000);
        step(1'b0, 16'h1234, 1'b1, 18'h00000);
        step(1'b1, 16'h57FF, 1'b1, 18'h07FF0);
        step(1'b1, 16'h5800, 1'b1, 18'h17FFF);
        step(1'b0, 16'h0000, 1'b1, 18'h00000);
        step(1'b0, 16'h0000, 1'b1, 18'h00000);
        step(1'b1, 16'hD800, 1'b1, 18'h08000);
        step(1'b1, 16'h7BFF, 1'b1, 18'h17FFF);
        step(1'b1, 16'hFE00, 1'b1, 18'h20000);

        // Rounding boundaries
        step(1'b1, 16'h1800, 1'b1, 18'h00000);
        step(1'b1, 16'h1E00, 1'b1, E_1E00);
        step(1'b1, 16'h1A00, 1'b0, 18'h0);
        step(1'b1, 16'h9A00, 1'b0, 18'h0);
        step(1'b1, 16'h9E00, 1'b0, 18'h0);
        step(1'b1, 16'h5BFF, 1'b0, 18'h0);
        step(1'b1, 16'hDBFF, 1'b0, 18'h0);
        step(1'b1, 16'h3BFF, 1'b0, 18'h0);
        step(1'b0, 16'h0000, 1'b1, 18'h0);

        // Mid-stream asynchronous reset with operands in flight
        step(1'b1, 16'h3C00, 1'b1, 18'h00100);
        step(1'b1, 16'h4000, 1'b1, 18'h00200);
        @(negedge clk);
        in_valid = 1'b1;
        fp16     = 16'h4400;
        #2;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset outputs", 32'({nan, sat, fixed8}), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("held reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        last.v = 1'b0;
        step(1'b0, 16'h0000, 1'b1, 18'h0);
        step(1'b0, 16'h0000, 1'b1, 18'h0);
        step(1'b1, 16'h3C00, 1'b1, 18'h00100);
        step(1'b0, 16'h0000, 1'b1, 18'h0);
        step(1'b0, 16'h0000, 1'b1, 18'h0);

        // Random operands with random gaps
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, 18'h0);
        end

        // Random operands concentrated on rounding and saturation exponents
        for (int i = 0; i < 300; i++) begin
            logic [15:0] x;
            x = {1'($urandom), 5'($urandom_range(1, 24)), 10'($urandom)};
            step(($urandom_range(0, 7) != 0), x, 1'b0, 18'h0);
        end

        step(1'b0, 16'h0000, 1'b1, 18'h0);
        step(1'b0, 16'h0000, 1'b1, 18'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
